// File: rtl/raster_pkg.sv
// raster_pkg: VGA 640x480 timing constants, the 256x240 playfield size, the bundled
// sync/blank type carried through the output delay line, and its decode helper.
package raster_pkg;

  localparam int unsigned H_VISIBLE    = 640;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 752;
  localparam int unsigned H_TOTAL      = 800;

  localparam int unsigned V_VISIBLE    = 480;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 492;
  localparam int unsigned V_TOTAL      = 525;

  localparam int unsigned PF_ROWS      = 240;
  localparam int unsigned PF_COLS      = 256;

  typedef struct packed {
    logic hsync_l;
    logic vsync_l;
    logic blank;
  } sync_t;

  // Inactive levels: both syncs released, display blanked.
  localparam sync_t SyncIdle = '{hsync_l: 1'b1, vsync_l: 1'b1, blank: 1'b1};

  function automatic sync_t sync_decode(input logic [9:0] h, input logic [9:0] v);
    sync_t s;
    s.hsync_l = !((h >= 10'(H_SYNC_START)) && (h < 10'(H_SYNC_END)));
    s.vsync_l = !((v >= 10'(V_SYNC_START)) && (v < 10'(V_SYNC_END)));
    s.blank   = (h >= 10'(H_VISIBLE)) || (v >= 10'(V_VISIBLE));
    return s;
  endfunction

endpackage

// File: rtl/raster_timing_if.sv
// raster_timing_if: scan-position bundle between the timing generator and its consumers.
//   irq_clr      - consumer pulse that releases the vblank interrupt
//   row/col      - playfield position (0 outside the game window)
//   game_active  - row/col inside the 512x480 game window
//   pix_en       - one-clk strobe per VGA pixel
//   hsync_l/vsync_l/blank - delay-matched DAC controls
//   irq_l        - vblank interrupt, active-low level
//   frame_cnt    - wrapping frame counter
interface raster_timing_if;
  logic       irq_clr;
  logic [7:0] row;
  logic [7:0] col;
  logic       game_active;
  logic       pix_en;
  logic       hsync_l;
  logic       vsync_l;
  logic       blank;
  logic       irq_l;
  logic [7:0] frame_cnt;

  // Timing generator side.
  modport master (
    input  irq_clr,
    output row, col, game_active, pix_en, hsync_l, vsync_l, blank, irq_l, frame_cnt
  );

  // Pipeline / CPU side.
  modport slave (
    output irq_clr,
    input  row, col, game_active, pix_en, hsync_l, vsync_l, blank, irq_l, frame_cnt
  );
endinterface

// File: rtl/sync_delay.sv
// sync_delay: Depth-stage, 3-bit shift register clocked every cycle, used to line up
// sync/blank with the downstream pixel pipeline. Each bit resets to its own ResetVal
// bit. Depth = 0 is a plain wire.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   d_i           - stage input
//   q_o           - output after Depth clocks
module sync_delay #(
  parameter int unsigned Depth    = 2,
  parameter logic [2:0]  ResetVal = 3'b111
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  if (Depth == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_pipe
    localparam int unsigned W = Depth * 3;

    logic [Depth-1:0][2:0] stage_q, stage_d;

    // Stage 0 takes d_i, stage i takes stage i-1; the oldest stage falls off the top.
    always_comb begin
      stage_d = W'({stage_q, d_i});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= {Depth{ResetVal}};
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/raster_timing.sv
// raster_timing: free-running VGA 640x480 scan generator. Derives the pixel strobe from
// clk, runs the horizontal/vertical/frame counters, maps the 512x480 game window onto
// the 256x240 playfield, produces delay-matched sync/blank and a vblank interrupt.
//   clk    - system clock
//   rst_l  - asynchronous active-low reset
//   bus    - raster_timing_if master: irq_clr in; row, col, game_active, pix_en,
//            hsync_l, vsync_l, blank, irq_l, frame_cnt out (all registered)
module raster_timing
  import raster_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned X_OFFSET = 64,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic            clk,
  input  logic            rst_l,
  raster_timing_if.master bus
);

  localparam int unsigned     DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0]      VVis     = 10'(V_VISIBLE);
  localparam logic [9:0]      WinStart = 10'(X_OFFSET);
  localparam logic [9:0]      WinEnd   = 10'(X_OFFSET + 2 * PF_COLS);
  localparam logic [9:0]      RowEnd   = 10'(2 * PF_ROWS);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]      hcnt_q, hcnt_d;
  logic [9:0]      vcnt_q, vcnt_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      row_q, row_d;
  logic [7:0]      col_q, col_d;
  logic            game_active_q, game_active_d;
  logic            pix_en_q, pix_en_d;
  logic            irq_l_q, irq_l_d;
  sync_t           sync_q, sync_d;
  sync_t           sync_out;

  logic pix;
  logic in_win;
  logic irq_set;

  // Pixel divider and scan counters.
  always_comb begin
    pix         = (div_cnt_q == DivLast);
    div_cnt_d   = pix ? '0 : div_cnt_q + 1'b1;
    pix_en_d    = (div_cnt_d == DivLast);
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    frame_cnt_d = frame_cnt_q;
    if (pix) begin
      if (hcnt_q == HLast) begin
        hcnt_d = '0;
        if (vcnt_q == VLast) begin
          vcnt_d      = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          vcnt_d = vcnt_q + 10'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // Registered decodes of the current counters.
  always_comb begin
    in_win        = (hcnt_q >= WinStart) && (hcnt_q < WinEnd) && (vcnt_q < RowEnd);
    game_active_d = in_win;
    row_d         = in_win ? vcnt_q[8:1] : '0;
    col_d         = in_win ? 8'((hcnt_q - WinStart) >> 1) : '0;
    sync_d        = sync_decode(hcnt_q, vcnt_q);
    // div_cnt_q == 0 only in the first clk after a counter update, so the interrupt
    // fires once even though the position is held for CLK_DIV clks.
    irq_set       = (hcnt_q == '0) && (vcnt_q == VVis) && (div_cnt_q == '0);
    // Set beats a coincident clear.
    irq_l_d       = irq_set ? 1'b0 : (bus.irq_clr ? 1'b1 : irq_l_q);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_cnt_q     <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_cnt_q   <= '0;
      row_q         <= '0;
      col_q         <= '0;
      game_active_q <= 1'b0;
      pix_en_q      <= 1'b0;
      irq_l_q       <= 1'b1;
      sync_q        <= SyncIdle;
    end else begin
      div_cnt_q     <= div_cnt_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      frame_cnt_q   <= frame_cnt_d;
      row_q         <= row_d;
      col_q         <= col_d;
      game_active_q <= game_active_d;
      pix_en_q      <= pix_en_d;
      irq_l_q       <= irq_l_d;
      sync_q        <= sync_d;
    end
  end

  // Extra PIPE_DLY clks so sync/blank reach the DAC alongside the rendered pixel.
  sync_delay #(
    .Depth    (PIPE_DLY),
    .ResetVal (SyncIdle)
  ) u_sync_delay (
    .clk_i  (clk),
    .rst_ni (rst_l),
    .d_i    (sync_q),
    .q_o    (sync_out)
  );

  assign bus.row         = row_q;
  assign bus.col         = col_q;
  assign bus.game_active = game_active_q;
  assign bus.pix_en      = pix_en_q;
  assign bus.hsync_l     = sync_out.hsync_l;
  assign bus.vsync_l     = sync_out.vsync_l;
  assign bus.blank       = sync_out.blank;
  assign bus.irq_l       = irq_l_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: doc/raster_timing.md
# raster_timing

Generates the scan position that drives the graphics pipeline. Free-running VGA 640x480 horizontal and vertical counters are derived from the system clock. The 512x480 game window, a 2x-scaled 256x240 playfield, is mapped to playfield `row`/`col` for the motion-object and tile stages. The block also produces delay-matched sync and blank for the DAC and a once-per-frame vblank interrupt to the 6502.

## Interface
- `CLK_DIV`, 2: `clk` cycles per VGA pixel (≥1).
- `X_OFFSET`, 64: first VGA column of the game window.
- `PIPE_DLY`, 2: extra `clk` delay on `hsync_l`/`vsync_l`/`blank` relative to `row`/`col` (0–7).
- `clk` input 1: system clock. One clock domain only.
- `rst_l` input 1: reset, asynchronous and active-low.
- `irq_clr` input 1: one-clk pulse that clears `irq_l`.
- `row` output 8: playfield row, 0–239.
- `col` output 8: playfield column, 0–255.
- `game_active` output 1: `row`/`col` lie inside the game window.
- `pix_en` output 1: one-clk strobe marking each VGA pixel.
- `hsync_l` output 1: horizontal sync, active-low.
- `vsync_l` output 1: vertical sync, active-low.
- `blank` output 1: outside the 640x480 visible area.
- `irq_l` output 1: vblank interrupt, active-low level.
- `frame_cnt` output 8: frame counter, wraps.

## Operation
- **Divider.** `div_cnt` counts 0..`CLK_DIV`-1. `pix_en` is high while `div_cnt`==`CLK_DIV`-1. With `CLK_DIV`=1, `pix_en` is constantly high.
- **Horizontal counter.** On `pix_en`, `hcnt` (10b) advances 0..799. At 799 it wraps to 0 and `vcnt` advances.
- **Vertical counter.** `vcnt` (10b) advances 0..524. At 524 it wraps to 0 and `frame_cnt` increments, 255→0.
- **Window decode** (from current counters):
  - `game_active` = (`X_OFFSET` ≤ `hcnt` < `X_OFFSET`+512) && (`vcnt` < 480).
  - `col` = (`hcnt`−`X_OFFSET`)[8:1].
  - `row` = `vcnt`[8:1].
  - Outside the window, `row` and `col` are forced to 0.
- **Sync/blank decode:**
  - `hsync_l` is low for 656 ≤ `hcnt` < 752.
  - `vsync_l` is low for 490 ≤ `vcnt` < 492.
  - `blank` = `hcnt` ≥ 640 || `vcnt` ≥ 480.
- **Interrupt.** `irq_l` falls on the `pix_en` that moves the counters to (`hcnt`=0, `vcnt`=480). It stays low until `irq_clr`.
  - `irq_clr` while `irq_l` is already high: no effect.
  - Set and `irq_clr` in the same clk: set wins, `irq_l` goes or stays low.
- **Reset values:** `div_cnt`, `hcnt`, `vcnt`, `row`, `col`, `frame_cnt` = 0; `game_active`=0, `pix_en`=0, `hsync_l`=1, `vsync_l`=1, `blank`=1, `irq_l`=1. Every delay-line stage resets to the inactive values (1, 1, 1). Asserting reset mid-frame restarts the frame at (0,0) with no sync glitch low.

## Timing
- Counters update on the `clk` edge where `pix_en` is high.
- `row`, `col` and `game_active` are registered decodes of the counters. They are valid 1 clk after each counter update and held for `CLK_DIV` clks.
- `hsync_l`, `vsync_l` and `blank` are the same-stage registered decodes passed through a `PIPE_DLY`-deep shift register clocked every clk. Total delay from counter update is 1+`PIPE_DLY` clks.
- `irq_l` is registered; it changes 1 clk after the triggering counter update.
- Pixel-exact periods: line = 800 pixels, frame = 525 lines, `hsync_l` low for 96 pixels, `vsync_l` low for 2 lines.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `raster_pkg`:
  - Constants `H_VISIBLE`=640, `H_SYNC_START`=656, `H_SYNC_END`=752, `H_TOTAL`=800.
  - Constants `V_VISIBLE`=480, `V_SYNC_START`=490, `V_SYNC_END`=492, `V_TOTAL`=525.
  - Constants `PF_ROWS`=240, `PF_COLS`=256.
- Sub-module `sync_delay`: a parameterised-depth, 3-bit-wide shift register with per-bit reset values. `PIPE_DLY`=0 degenerates to a wire.

## Test plan
All scenarios use `CLK_DIV`=2, `PIPE_DLY`=2.
1. **Reset.** Assert `rst_l`=0 mid-line → all outputs at reset values immediately. Release → first `pix_en` 2 clks later; `hcnt` reaches 1 on that edge.
2. **Window.** At `hcnt`=64, `vcnt`=0 → `row`=0, `col`=0, `game_active`=1 one clk later. At `hcnt`=575 → `col`=255. At `hcnt`=576 → `game_active`=0, `col`=0. At `vcnt`=479 → `row`=239.
3. **Sync.**
   - `hsync_l` low for exactly 192 clks per line, falling 3 clks after `hcnt` becomes 656.
   - `vsync_l` low for exactly 3200 clks per frame.
   - `blank` rises 3 clks after `hcnt` becomes 640.
4. **Interrupt.**
   - `irq_l` falls 1 clk after counters reach (0,480).
   - `irq_clr` pulse → high next clk.
   - `irq_clr` on the set clk → `irq_l` stays low.
   - `irq_clr` while high → no change.
5. **Frame wrap.** After 840000 clks the counters return to (0,0) and `frame_cnt` goes 0→1. Preset `frame_cnt` to 255 → wraps to 0. Line period is always 1600 clks.
6. **Reset mid-vsync.** Pulse `rst_l` while `vsync_l`=0 → `vsync_l`=1 immediately. The next frame begins at `hcnt`=`vcnt`=0 with correct periods.
